ro_sensor_array: RTL and testbench
==================================

# ro_sensor_array

Parametrised array of enable-gated ring-oscillator sensors with on-chip frequency measurement. It is the next generation of the open-ended inverter-chain sensor: each channel closes its chain into a ring and counts the ring's edges. A clock-domain controller measures every enabled channel over a programmable window. It sits in the hwdbg sensors area and reports per-channel edge counts to the debugger logic.

## Interface
- NUM_CH, 4: number of oscillator channels.
- STAGES, 2000: inverters per ring, excluding the head NAND. Must be even, so total inversion is odd.
- CNT_W, 16: per-channel edge-counter and result width.
- WIN_W, 16: window-length width.
- SETTLE_CYCLES, 16: clock cycles between enabling the rings and the start snapshot. Must be ≥ 4.
- SIM_STAGE_PS, 0: behavioural per-stage delay, simulation only. 0 means no delay annotation.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  measurement request; sampled only in IDLE.
- window_len  in  WIN_W  measurement window in clock cycles; latched on start.
- ch_mask  in  NUM_CH  channel enables; latched on start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; count is valid from this cycle.
- count  out  NUM_CH*CNT_W  per-channel edge counts; channel i occupies bits [i*CNT_W +: CNT_W].
- ro_out  out  NUM_CH  raw ring outputs, for pin probing.

## Operation
- States: IDLE, SETTLE, MEASURE, DONE. All are encoded in the package enum.
- IDLE:
  - All ring enables are low.
  - When start=1, latch window_len and ch_mask, raise the masked enables, and go to SETTLE.
- SETTLE: runs SETTLE_CYCLES cycles, so the rings start and the synchronisers fill. On the last cycle, snapshot each channel's synchronised, binary-converted count into start_val[i].
- MEASURE:
  - Runs window_len cycles.
  - On the last cycle, compute count[i] = (cur[i] − start_val[i]) mod 2^CNT_W for masked channels, and 0 for unmasked channels.
  - Drop all enables and go to DONE.
  - If window_len = 0, MEASURE is skipped: all counts are 0 and the FSM goes from SETTLE directly to DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0. Go to IDLE.
  - start is not accepted in DONE. It is accepted from the following cycle.
- start while busy: ignored, with no effect on the latched parameters.
- Each ring has a NAND head (enable, feedback) followed by STAGES inverters. ro_out is the last stage.
- Per-channel edge counter:
  - CNT_W-bit Gray counter, clocked by the ring output's rising edge, asynchronously cleared by reset.
  - Holds its value while the ring is disabled.
  - Sampled into the clock domain with a 2-flop synchroniser, then converted Gray→binary.
- Accuracy: ±1 count, provided the ring period exceeds the flop aperture.
- Wrap-around: the result is modulo 2^CNT_W. No overflow flag is provided; software sizes window_len accordingly.
- count holds its value until the next DONE.

## Timing
- Reset values: busy=0, done=0, count=0, enables=0, therefore ro_out=0. Gray counters are 0.
- Reset is asynchronous: asserting it mid-operation forces the reset values immediately, state=IDLE, and latched parameters are discarded.
- Latency: if start is sampled at edge k, then busy=1 from k+1, and done=1 with count valid in cycle k+1+SETTLE_CYCLES+window_len.
- Enables rise at k+1 and fall after the last MEASURE cycle.
- The start and end snapshots use the same synchroniser latency, so the lag cancels.

## Structure
- Package ro_sensor_pkg contains:
  - state_t enum;
  - gray2bin and bin2gray functions;
  - localparam checks: STAGES even, SETTLE_CYCLES ≥ 4.
- Sub-module ro_cell, one per channel:
  - NAND head plus STAGES dont_touch instances of the existing inverter cell, generate loop;
  - Gray counter and 2-flop synchroniser;
  - outputs the binary synchronised count and ro_out.
- Top level: FSM, window counter, snapshot registers, subtractors.

## Test plan
All scenarios use a 10 ns clock, STAGES=4 and SIM_STAGE_PS=500, which gives a 5 ns ring period and 2 edges per clock.
- ch_mask=0001, window_len=100, start at edge k → done exactly at k+117; count0 ∈ [199,201]; count1..3 = 0; ro_out[3:1] stay 0.
- ch_mask=1111, window_len=50 → every count ∈ [99,101]; single done pulse; busy high for 66 cycles.
- window_len=0 → done at k+17; all counts 0.
- start held high throughout a run, and a second start pulse during MEASURE → exactly one done; latched window unchanged; the next start is accepted in the cycle after DONE.
- reset asserted during MEASURE → busy, done, count and ro_out are 0 before the next clock edge; a subsequent run with window_len=100 gives 200±1.
- CNT_W=8, window_len=200 → count0 = 400 mod 256 = 144 ± 1.

Source files
------------

// File: rtl/ro_sensor_pkg.sv
// Shared state encoding, Gray/binary helpers and parameter sanity checks for the ring-oscillator sensor array.
// Pure definitions; no logic, no latency.
package ro_sensor_pkg;
  timeunit 1ns;
  timeprecision 1ps;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Conversion helpers work on a fixed width; callers zero-extend and keep the low bits.
  localparam int GRAY_W            = 32;
  localparam int MIN_SETTLE_CYCLES = 4;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic bit stages_ok(input int stages);
    return (stages > 0) && ((stages % 2) == 0);
  endfunction

  function automatic bit settle_ok(input int cycles);
    return cycles >= MIN_SETTLE_CYCLES;
  endfunction
endpackage

// File: rtl/ro_cell.sv
// One sensor channel: enable-gated ring, Gray edge counter in the ring domain, 2-flop synchroniser into clk.
// cnt_o trails the ring counter by two clk cycles; ro_o is 0 whenever the channel is disabled.
module ro_cell
  import ro_sensor_pkg::*;
#(
  parameter int STAGES       = 2000,
  parameter int CNT_W        = 16,
  parameter int SIM_STAGE_PS = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ro_o
);
  timeunit 1ns;
  timeprecision 1ps;

  logic [STAGES:0]   node_w;
  logic              ro_gated_w;
  logic [CNT_W-1:0]  gray_q, gray_d;
  logic [CNT_W-1:0]  sync1_q, sync2_q;
  logic [GRAY_W-1:0] bin_cur_w, gray_nxt_w, bin_sync_w;
  logic [CNT_W-1:0]  bin_nxt_w;

  ro_nand2_cell #(.DLY_PS(SIM_STAGE_PS)) u_head (
    .a_i (en_i),
    .b_i (node_w[STAGES]),
    .y_o (node_w[0])
  );

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    (* dont_touch = "true" *)
    ro_inv_cell #(.DLY_PS(SIM_STAGE_PS)) u_inv (
      .a_i (node_w[s]),
      .y_o (node_w[s+1])
    );
  end

  // A disabled ring rests high at its tail, so gating keeps the probe and the counter clock quiet.
  assign ro_gated_w = node_w[STAGES] & en_i;
  assign ro_o       = ro_gated_w;

  always_comb begin
    bin_cur_w  = gray2bin(GRAY_W'(gray_q));
    bin_nxt_w  = bin_cur_w[CNT_W-1:0] + CNT_W'(1);
    gray_nxt_w = bin2gray(GRAY_W'(bin_nxt_w));
    gray_d     = gray_nxt_w[CNT_W-1:0];
  end

  always_ff @(posedge ro_gated_w or posedge rst_i) begin
    if (rst_i) gray_q <= '0;
    else       gray_q <= gray_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gray_q;
      sync2_q <= sync1_q;
    end
  end

  assign bin_sync_w = gray2bin(GRAY_W'(sync2_q));
  assign cnt_o      = bin_sync_w[CNT_W-1:0];

  if (CNT_W < GRAY_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{bin_cur_w[GRAY_W-1:CNT_W], gray_nxt_w[GRAY_W-1:CNT_W],
                         bin_sync_w[GRAY_W-1:CNT_W]};
  end
  if (CNT_W > GRAY_W) begin : g_chk_w
    $error("ro_cell: CNT_W exceeds the Gray helper width");
  end
endmodule

// File: rtl/ro_sensor_cells.sv
// Leaf cells of the ring: inverter and 2-input NAND, each with an optional behavioural stage delay.
// Combinational; the delay branch exists only so a ring can oscillate in event-driven simulation.
module ro_inv_cell #(
  parameter int DLY_PS = 0
) (
  input  logic a_i,
  output logic y_o
);
  timeunit 1ns;
  timeprecision 1ps;

  if (DLY_PS > 0) begin : g_dly
    assign #(DLY_PS * 1ps) y_o = ~a_i;
  end else begin : g_nodly
    assign y_o = ~a_i;
  end
endmodule

module ro_nand2_cell #(
  parameter int DLY_PS = 0
) (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  timeunit 1ns;
  timeprecision 1ps;

  if (DLY_PS > 0) begin : g_dly
    assign #(DLY_PS * 1ps) y_o = ~(a_i & b_i);
  end else begin : g_nodly
    assign y_o = ~(a_i & b_i);
  end
endmodule

// File: rtl/ro_sensor_array.sv
// Ring-oscillator sensor array: settles enabled rings, measures edge deltas over window_len clocks.
// start accepted only in IDLE; done arrives 1+SETTLE_CYCLES+window_len cycles after the accepting edge.
module ro_sensor_array
  import ro_sensor_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STAGES        = 2000,
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int SIM_STAGE_PS  = 0
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [WIN_W-1:0]        window_len_i,
  input  logic [NUM_CH-1:0]       ch_mask_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic [NUM_CH-1:0]       ro_out_o
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

  if (!stages_ok(STAGES)) begin : g_chk_stages
    $error("ro_sensor_array: STAGES must be a positive even number");
  end
  if (!settle_ok(SETTLE_CYCLES)) begin : g_chk_settle
    $error("ro_sensor_array: SETTLE_CYCLES too small for the synchroniser to fill");
  end

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [TMR_W-1:0]  win_last_w;
  logic [CNT_W-1:0]  cur_w   [NUM_CH];
  logic [CNT_W-1:0]  start_q [NUM_CH];
  logic [CNT_W-1:0]  start_d [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ro_cell #(
      .STAGES       (STAGES),
      .CNT_W        (CNT_W),
      .SIM_STAGE_PS (SIM_STAGE_PS)
    ) u_cell (
      .clk_i (clock_i),
      .rst_i (reset_i),
      .en_i  (en_q[i]),
      .cnt_o (cur_w[i]),
      .ro_o  (ro_out_o[i])
    );
    assign count_o[i*CNT_W +: CNT_W] = count_q[i];
  end

  assign win_last_w = TMR_W'(win_q) - TMR_W'(1);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    mask_d  = mask_q;
    en_d    = en_q;
    tmr_d   = tmr_q;
    start_d = start_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        en_d = '0;
        if (start_i) begin
          win_d   = window_len_i;
          mask_d  = ch_mask_i;
          en_d    = ch_mask_i;
          tmr_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == SETTLE_LAST) begin
          start_d = cur_w;
          tmr_d   = '0;
          if (win_q == '0) begin
            for (int i = 0; i < NUM_CH; i++) count_d[i] = '0;
            en_d    = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_MEASURE;
          end
        end
      end
      ST_MEASURE: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == win_last_w) begin
          // Modular subtraction absorbs counter wrap inside the window.
          for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = mask_q[i] ? (cur_w[i] - start_q[i]) : '0;
          end
          en_d    = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      mask_q  <= '0;
      en_q    <= '0;
      tmr_q   <= '0;
      start_q <= '{default: '0};
      count_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      tmr_q   <= tmr_d;
      start_q <= start_d;
      count_q <= count_d;
    end
  end

  assign busy_o = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
  assign done_o = (state_q == ST_DONE);
endmodule

// File: tb/tb_ro_sensor_array.sv
// Bench for ro_sensor_array with 4-stage rings at 500 ps/stage (5 ns period, two edges per 10 ns clock).
// Directed table, random runs against an edge-rate model, and corner sequences (held start, reset, narrow counter).
module tb_ro_sensor_array;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int NUM_CH  = 4;
  localparam int STAGES  = 4;
  localparam int SIM_PS  = 500;
  localparam int SETTLE  = 16;
  localparam int CNT_W   = 16;
  localparam int CNT8_W  = 8;
  localparam int WIN_W   = 16;
  localparam int CLK_PS  = 10000;
  localparam int RING_PS = 2 * (STAGES + 1) * SIM_PS;

  typedef struct {
    logic [3:0] m;
    int         w;
    int         lat;
    int         cnt;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start8 = 1'b0;
  logic [WIN_W-1:0] win = '0, win8 = '0;
  logic [NUM_CH-1:0] mask = '0, mask8 = '0;
  logic busy, done, busy8, done8;
  logic [NUM_CH*CNT_W-1:0]  count;
  logic [NUM_CH*CNT8_W-1:0] count8;
  logic [NUM_CH-1:0] ro, ro8;
  int checks = 0, errors = 0, cyc = 0;

  ro_sensor_array #(.NUM_CH(NUM_CH), .STAGES(STAGES), .CNT_W(CNT_W), .WIN_W(WIN_W),
                    .SETTLE_CYCLES(SETTLE), .SIM_STAGE_PS(SIM_PS)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .window_len_i(win), .ch_mask_i(mask),
    .busy_o(busy), .done_o(done), .count_o(count), .ro_out_o(ro));

  ro_sensor_array #(.NUM_CH(NUM_CH), .STAGES(STAGES), .CNT_W(CNT8_W), .WIN_W(WIN_W),
                    .SETTLE_CYCLES(SETTLE), .SIM_STAGE_PS(SIM_PS)) dut8 (
    .clock_i(clk), .reset_i(rst), .start_i(start8), .window_len_i(win8), .ch_mask_i(mask8),
    .busy_o(busy8), .done_o(done8), .count_o(count8), .ro_out_o(ro8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected edges: window time divided by ring period, reduced modulo the counter range.
  function automatic int model_edges(input int w, input int cw);
    longint e;
    e = longint'(w) * CLK_PS / RING_PS;
    return int'(e % (longint'(1) << cw));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int cw);
    int d;
    checks++;
    d = (act - exp) & ((1 << cw) - 1);
    if (!(d == 0 || d == 1 || d == (1 << cw) - 1)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    end
  endtask

  task automatic wait_for_done(input bit narrow, input int limit, output int dc);
    dc = -1;
    for (int t = 0; t < limit && dc < 0; t++) begin
      @(negedge clk);
      if (narrow ? done8 : done) dc = cyc + 1;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] m, input int w, input int lat, input int cnt);
    int k, busy_n, dones, dc, c;
    logic [3:0] leak;
    busy_n = 0; dones = 0; dc = -1; leak = '0;
    @(negedge clk);
    k = cyc + 1; start = 1'b1; win = WIN_W'(w); mask = m;
    for (int t = 0; t < SETTLE + w + 10; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (dc < 0) dc = cyc + 1;
      end
      leak |= ro & ~m;
    end
    check($sformatf("%s_latency", tag), dc - k, lat);
    check($sformatf("%s_busy_cycles", tag), busy_n, SETTLE + w);
    check($sformatf("%s_done_pulses", tag), dones, 1);
    check($sformatf("%s_idle_ro", tag), leak, 0);
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(count[i*CNT_W +: CNT_W]);
      if (m[i] && w != 0) check_near($sformatf("%s_cnt%0d", tag, i), c, cnt, CNT_W);
      else                check($sformatf("%s_cnt%0d", tag, i), c, 0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int k, k2, dc, w;
    logic [3:0] m;

    tbl[0] = '{4'b0001, 100, 1 + SETTLE + 100, 200};
    tbl[1] = '{4'b1111,  50, 1 + SETTLE + 50,  100};
    tbl[2] = '{4'b1010,   0, 1 + SETTLE,       0};
    tbl[3] = '{4'b0110,  20, 1 + SETTLE + 20,  40};
    tbl[4] = '{4'b1000,   7, 1 + SETTLE + 7,   14};

    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_ro", ro, 0);
    check("rst_busy8", busy8, 0);
    check("rst_count8", count8, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].m, tbl[i].w, tbl[i].lat, tbl[i].cnt);
    end

    for (int i = 0; i < 6; i++) begin
      m = 4'($urandom_range(1, 15));
      w = int'($urandom_range(0, 40));
      run($sformatf("rnd%0d", i), m, w, 1 + SETTLE + w, model_edges(w, CNT_W));
    end

    // start held through a whole run; parameters changed mid-MEASURE must not leak in.
    @(negedge clk);
    k = cyc + 1; start = 1'b1; win = 16'd30; mask = 4'b0011;
    repeat (SETTLE + 10) @(negedge clk);
    win = 16'd5; mask = 4'b1111;
    wait_for_done(1'b0, 60, dc);
    check("held_latency", dc - k, 1 + SETTLE + 30);
    check_near("held_cnt0", int'(count[15:0]), model_edges(30, CNT_W), CNT_W);
    check_near("held_cnt1", int'(count[31:16]), model_edges(30, CNT_W), CNT_W);
    check("held_cnt2", count[47:32], 0);
    check("held_cnt3", count[63:48], 0);
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    check("held_idle_done", done, 0);
    k2 = cyc + 1;
    @(negedge clk);
    check("held_accept", busy, 1);
    start = 1'b0;
    wait_for_done(1'b0, 40, dc);
    check("held2_latency", dc - k2, 1 + SETTLE + 5);
    for (int i = 0; i < NUM_CH; i++) begin
      check_near($sformatf("held2_cnt%0d", i), int'(count[i*CNT_W +: CNT_W]),
                 model_edges(5, CNT_W), CNT_W);
    end

    // Reset during MEASURE clears outputs without waiting for a clock edge.
    @(negedge clk);
    start = 1'b1; win = 16'd100; mask = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 20) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_ro", ro, 0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", 4'b0001, 100, 1 + SETTLE + 100, model_edges(100, CNT_W));

    // Narrow counter wraps inside the window.
    @(negedge clk);
    k = cyc + 1; start8 = 1'b1; win8 = 16'd200; mask8 = 4'b0001;
    @(negedge clk);
    start8 = 1'b0;
    wait_for_done(1'b1, SETTLE + 220, dc);
    check("n8_latency", dc - k, 1 + SETTLE + 200);
    check_near("n8_cnt0", int'(count8[7:0]), model_edges(200, CNT8_W), CNT8_W);
    check("n8_cnt1", count8[15:8], 0);
    check("n8_cnt2", count8[23:16], 0);
    check("n8_cnt3", count8[31:24], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
